// File: rtl/if_fetch_q.sv
// Instruction fetch unit: single-outstanding memory requester feeding a small in-order
// fetch queue whose head drives the decode interface; redirects flush the queue and steer the PC.
module if_fetch_q #(
    parameter int              AW       = 16,
    parameter int              DW       = 16,
    parameter int              OFF_W    = 11,
    parameter int              DEPTH    = 2,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redir_valid_i,
    input  logic             redir_abs_i,
    input  logic [AW-1:0]    redir_base_i,
    input  logic [OFF_W-1:0] redir_off_i,
    input  logic [AW-1:0]    redir_addr_i,
    output logic             imem_req_o,
    output logic [AW-1:0]    imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [DW-1:0]    imem_rdata_i,
    output logic             id_valid_o,
    input  logic             id_ready_i,
    output logic [DW-1:0]    id_instr_o,
    output logic [AW-1:0]    id_pc_o,
    output logic [AW-1:0]    id_pc_next_o,
    output logic [1:0]       dbg_state_o
);
    // Handshakes: imem request transfers when imem_req_o && imem_gnt_i; decode transfer
    // (pop) when id_valid_o && id_ready_i; both are void in a cycle with redir_valid_i high.
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   pc_q;
    logic [AW-1:0]   req_pc_q;
    logic            drop_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [DW-1:0]   instr_q [DEPTH];
    logic [DW-1:0]   instr_d [DEPTH];
    logic [AW-1:0]   epc_q   [DEPTH];
    logic [AW-1:0]   epc_d   [DEPTH];
    logic [AW-1:0]   target;
    logic [AW-1:0]   pc_inc;
    logic [CW-1:0]   wr_idx;
    logic            push;
    logic            pop;
    logic            space_after;

    assign id_valid_o   = (cnt_q != '0);
    assign id_instr_o   = instr_q[0];
    assign id_pc_o      = epc_q[0];
    assign id_pc_next_o = id_valid_o ? epc_q[0] + AW'(1) : '0;
    assign imem_req_o   = (state_q == S_REQ) && !rst;
    assign imem_addr_o  = pc_q;
    assign dbg_state_o  = state_q;

    // Queue is a shift register with the head in slot 0, so id_* come straight from flops.
    always_comb begin
        target      = redir_abs_i ? redir_addr_i
                    : redir_base_i + {{(AW-OFF_W){redir_off_i[OFF_W-1]}}, redir_off_i};
        pc_inc      = pc_q + AW'(1);
        pop         = id_valid_o && id_ready_i && !redir_valid_i;
        push        = (state_q == S_WAIT) && imem_rvalid_i && !drop_q && !redir_valid_i;
        wr_idx      = cnt_q - CW'(pop);
        for (int i = 0; i < DEPTH; i++) begin
            instr_d[i] = instr_q[i];
            epc_d[i]   = epc_q[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                instr_d[i] = instr_q[i+1];
                epc_d[i]   = epc_q[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    instr_d[i] = imem_rdata_i;
                    epc_d[i]   = req_pc_q;
                end
            end
        end
        cnt_d       = redir_valid_i ? '0 : cnt_q + CW'(push) - CW'(pop);
        space_after = int'(cnt_d) < DEPTH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                epc_q[i]   <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= instr_d[i];
                epc_q[i]   <= epc_d[i];
            end
            case (state_q)
                S_REQ: begin
                    if (imem_gnt_i) begin
                        state_q  <= S_WAIT;
                        req_pc_q <= pc_q;
                        drop_q   <= redir_valid_i;
                        pc_q     <= redir_valid_i ? target : pc_inc;
                    end else if (redir_valid_i) begin
                        pc_q <= target;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        drop_q <= 1'b0;
                        if (redir_valid_i || drop_q) begin
                            state_q <= S_REQ;
                        end else begin
                            state_q <= space_after ? S_REQ : S_HOLD;
                        end
                        if (redir_valid_i) begin
                            pc_q <= target;
                        end
                    end else if (redir_valid_i) begin
                        drop_q <= 1'b1;
                        pc_q   <= target;
                    end
                end
                S_HOLD: begin
                    if (redir_valid_i) begin
                        state_q <= S_REQ;
                        pc_q    <= target;
                    end else if (pop) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_q.sv
// Bench for if_fetch_q: randomized memory/decode/redirect traffic checked against a
// program-order model (expected fetch address and expected decoded PC streams).
module tb_if_fetch_q;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int OFF_W = 11;
    localparam int DEPTH = 2;
    localparam logic [AW-1:0] RESET_PC = 16'h0000;

    logic             clk;
    logic             rst;
    logic             redir_valid_i;
    logic             redir_abs_i;
    logic [AW-1:0]    redir_base_i;
    logic [OFF_W-1:0] redir_off_i;
    logic [AW-1:0]    redir_addr_i;
    logic             imem_req_o;
    logic [AW-1:0]    imem_addr_o;
    logic             imem_gnt_i;
    logic             imem_rvalid_i;
    logic [DW-1:0]    imem_rdata_i;
    logic             id_valid_o;
    logic             id_ready_i;
    logic [DW-1:0]    id_instr_o;
    logic [AW-1:0]    id_pc_o;
    logic [AW-1:0]    id_pc_next_o;
    logic [1:0]       dbg_state_o;

    if_fetch_q #(.AW(AW), .DW(DW), .OFF_W(OFF_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .redir_valid_i(redir_valid_i), .redir_abs_i(redir_abs_i),
        .redir_base_i(redir_base_i), .redir_off_i(redir_off_i), .redir_addr_i(redir_addr_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o),
        .id_pc_o(id_pc_o), .id_pc_next_o(id_pc_next_o), .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // knobs (percentages) and memory model
    int gnt_pct = 100, rv_pct = 100, rdy_pct = 100, stray_pct = 0, lat = 1;
    logic [DW-1:0] data_xor = '0;
    bit            mem_busy = 0;
    logic [AW-1:0] mem_addr = '0;
    int            mem_wait = 0;

    // program-order model
    logic [AW-1:0] exp_pc   = RESET_PC;
    logic [AW-1:0] fetch_pc = RESET_PC;
    logic [AW-1:0] obs_q[$];

    // one-shot redirect request and armed same-cycle gnt/pop/redirect case
    bit            do_redir = 0;
    logic          r_abs = 0;
    logic [AW-1:0] r_base = '0, r_addr = '0;
    logic [OFF_W-1:0] r_off = '0;
    bit            arm_045 = 0, fired_045 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] ref_target(input logic abs, input logic [AW-1:0] base,
                                                 input logic [OFF_W-1:0] off,
                                                 input logic [AW-1:0] addr);
        logic signed [OFF_W-1:0] soff;
        int sum;
        soff = off;
        sum  = int'(base) + int'(soff);
        return abs ? addr : sum[AW-1:0];
    endfunction

    // driver: one cycle of stimulus decided at the falling edge, scored against the model
    task automatic step();
        logic rv, g, rdy;
        logic [AW-1:0] tgt;
        @(negedge clk);
        rv = 1'b0;
        imem_rdata_i = DW'($urandom);
        if (mem_busy) begin
            if (mem_wait > 0) mem_wait--;
            else if ($urandom_range(99) < rv_pct) begin
                rv = 1'b1;
                imem_rdata_i = mem_addr ^ data_xor;
                mem_busy = 0;
            end
        end else if ($urandom_range(99) < stray_pct) begin
            rv = 1'b1;
        end
        g   = imem_req_o && ($urandom_range(99) < gnt_pct);
        rdy = ($urandom_range(99) < rdy_pct);
        if (arm_045 && imem_req_o && id_valid_o) begin
            g = 1'b1; rdy = 1'b1; do_redir = 1; r_abs = 1'b1; r_addr = 16'h1234;
            arm_045 = 0; fired_045 = 1;
        end
        imem_rvalid_i = rv;
        imem_gnt_i    = g;
        id_ready_i    = rdy;
        redir_valid_i = do_redir;
        redir_abs_i   = r_abs;
        redir_base_i  = r_base;
        redir_off_i   = r_off;
        redir_addr_i  = r_addr;
        tgt = ref_target(r_abs, r_base, r_off, r_addr);
        if (g) begin
            check("fetch_addr", imem_addr_o, fetch_pc);
            fetch_pc = fetch_pc + 1'b1;
            mem_busy = 1;
            mem_addr = imem_addr_o;
            mem_wait = lat - 1;
        end
        if (id_valid_o && rdy && !do_redir) begin
            check("pop_pc", id_pc_o, exp_pc);
            check("pop_instr", id_instr_o, exp_pc ^ data_xor);
            check("pop_pc_next", id_pc_next_o, AW'(exp_pc + 1'b1));
            obs_q.push_back(id_pc_o);
            exp_pc = exp_pc + 1'b1;
        end
        if (do_redir) begin
            exp_pc   = tgt;
            fetch_pc = tgt;
        end
        do_redir = 0;
    endtask

    task automatic do_reset(input bit clear_mem);
        @(negedge clk);
        rst = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        redir_valid_i = 1'b0; id_ready_i = 1'b0;
        @(negedge clk);
        check("rst_imem_req", imem_req_o, 0);
        check("rst_id_valid", id_valid_o, 0);
        check("rst_id_instr", id_instr_o, 0);
        check("rst_id_pc", id_pc_o, 0);
        check("rst_id_pc_next", id_pc_next_o, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = RESET_PC;
        fetch_pc = RESET_PC;
        if (clear_mem) mem_busy = 0;
    endtask

    task automatic run_until_pops(input int n, input int limit, input string tag);
        int k;
        k = 0;
        while (obs_q.size() < n && k < limit) begin
            step();
            k++;
        end
        check(tag, (obs_q.size() >= n), 1);
    endtask

    initial begin
        rst = 1'b1; redir_valid_i = 0; redir_abs_i = 0; redir_base_i = '0; redir_off_i = '0;
        redir_addr_i = '0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0; id_ready_i = 0;

        // streaming with 1-cycle memory returning address as data
        do_reset(1);
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100; lat = 1; data_xor = '0;
        step();
        check("first_req", imem_req_o, 1);
        check("first_addr", imem_addr_o, RESET_PC);
        step();
        check("lat_t1_invalid", id_valid_o, 0);
        step();
        check("lat_t2_valid", id_valid_o, 1);
        check("lat_t2_pc", id_pc_o, RESET_PC);
        repeat (20) step();

        // backpressure fills the queue then drains exactly two entries
        do_reset(1);
        rdy_pct = 0;
        repeat (10) step();
        check("hold_no_req", imem_req_o, 0);
        check("hold_head_valid", id_valid_o, 1);
        check("hold_head_pc", id_pc_o, 16'h0000);
        obs_q.delete();
        rdy_pct = 100; gnt_pct = 0;
        step();
        step();
        check("hold_exit_req", imem_req_o, 1);
        check("hold_exit_addr", imem_addr_o, 16'h0002);
        step();
        check("drained", id_valid_o, 0);
        check("drain_pops", obs_q.size(), 2);
        gnt_pct = 100;

        // relative redirect while a fetch is outstanding
        do_reset(1);
        lat = 4;
        step();
        r_abs = 0; r_base = 16'h0010; r_off = 11'h7FE; do_redir = 1;
        obs_q.delete();
        step();
        lat = 1;
        run_until_pops(1, 40, "rel_pop_seen");
        if (obs_q.size() > 0) check("rel_first_pc", obs_q[0], 16'h000E);

        // absolute redirect to the top of the address space, wrap to zero
        r_abs = 1; r_addr = 16'hFFFF; do_redir = 1;
        step();
        obs_q.delete();
        run_until_pops(2, 40, "abs_pops_seen");
        if (obs_q.size() > 1) begin
            check("abs_first_pc", obs_q[0], 16'hFFFF);
            check("abs_wrap_pc", obs_q[1], 16'h0000);
        end

        // redirect coinciding with a grant and a blocked pop
        do_reset(1);
        rdy_pct = 0; arm_045 = 1; fired_045 = 0;
        for (int k = 0; k < 20 && !fired_045; k++) step();
        check("same_cycle_fired", fired_045, 1);
        arm_045 = 0; rdy_pct = 100;
        obs_q.delete();
        run_until_pops(1, 40, "same_cycle_pop_seen");
        if (obs_q.size() > 0) check("same_cycle_first_pc", obs_q[0], 16'h1234);

        // reset while waiting, then a stray response
        do_reset(1);
        lat = 5;
        step();
        step();
        do_reset(0);
        gnt_pct = 0; rv_pct = 100;
        for (int k = 0; k < 10 && mem_busy; k++) step();
        check("stray_delivered", mem_busy, 0);
        gnt_pct = 100; lat = 1;
        obs_q.delete();
        run_until_pops(1, 20, "post_rst_pop_seen");
        if (obs_q.size() > 0) check("post_rst_first_pc", obs_q[0], RESET_PC);

        // randomized traffic
        do_reset(1);
        data_xor = 16'hC3A5;
        obs_q.delete();
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                gnt_pct = $urandom_range(100, 30);
                rv_pct  = $urandom_range(100, 30);
                rdy_pct = $urandom_range(100, 20);
                lat     = $urandom_range(3, 1);
                stray_pct = $urandom_range(5, 0);
            end
            if ($urandom_range(99) < 4) begin
                do_redir = 1;
                r_abs  = 1'($urandom_range(1));
                r_base = AW'($urandom);
                r_off  = OFF_W'($urandom);
                r_addr = ($urandom_range(3) == 0) ? 16'hFFFE : AW'($urandom);
            end
            step();
        end
        check("random_progress", (obs_q.size() > 100), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
